// File: rtl/spraid_spi_channel.sv
`default_nettype none
// ============================================================================
// Module   : spraid_spi_channel
// Purpose  : Single-drive SPI-SRAM transfer engine. One 32-bit word request
//            becomes a framed transaction: command byte, ADDR_BYTES address
//            bytes (MSB first), then 4 data bytes (byte at addr+0 first).
//            Mode-0 SCLK, active-low chip select, all outputs registered.
// Ports    : clk, reset (async, active high)
//            start/we/addr/din  - request, sampled only when idle
//            dout/busy/done     - read data, in-progress flag, 1-cycle done
//            spi_clk/spi_cs/spi_mosi/spi_miso - serial interface
// Revision : 1.0 - initial release
// ============================================================================
module spraid_spi_channel #(
   parameter int          CLK_DIV    = 2,
   parameter int          ADDR_BYTES = 3,
   parameter logic [7:0]  CMD_READ   = 8'h03,
   parameter logic [7:0]  CMD_WRITE  = 8'h02
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        busy,
   output logic        done,
   output logic        spi_clk,
   output logic        spi_cs,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int c_NBITS = 8 * (1 + ADDR_BYTES + 4);
   localparam int c_ABITS = 8 * ADDR_BYTES;
   localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_BIT_W = $clog2(c_NBITS);

   localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);
   localparam logic [c_BIT_W-1:0] c_BIT_MAX = c_BIT_W'(c_NBITS - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_ONE = c_BIT_W'(1);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_SETUP = 3'd1;
   localparam logic [2:0] c_SHIFT = 3'd2;
   localparam logic [2:0] c_HOLD  = 3'd3;
   localparam logic [2:0] c_DESEL = 3'd4;

   logic [2:0]         r_state, w_state_nxt;
   logic [c_DIV_W-1:0] r_div,   w_div_nxt;
   logic [c_BIT_W-1:0] r_bit,   w_bit_nxt;
   logic [c_NBITS-1:0] r_shift, w_shift_nxt;
   logic [31:0]        r_rx,    w_rx_nxt;
   logic [31:0]        r_dout,  w_dout_nxt;
   logic               r_we,    w_we_nxt;
   logic               r_busy,  w_busy_nxt;
   logic               r_done,  w_done_nxt;
   logic               r_sclk,  w_sclk_nxt;
   logic               r_cs,    w_cs_nxt;
   logic               r_mosi,  w_mosi_nxt;

   logic               w_div_last;
   logic               w_bit_last;
   logic [c_NBITS-1:0] w_frame;
   logic [31:0]        w_wdata;
   logic               w_unused_addr;

   // Every phase (setup, sclk low, sclk high, hold, desel) is CLK_DIV cycles,
   // so one free-running divider that wraps at CLK_DIV-1 times all of them.
   assign w_div_last = (r_div == c_DIV_MAX);
   assign w_bit_last = (r_bit == c_BIT_MAX);

   // Data bytes go out lowest-address first; a read sends zeros.
   assign w_wdata = we ? {din[7:0], din[15:8], din[23:16], din[31:24]} : 32'h0;
   assign w_frame = {(we ? CMD_WRITE : CMD_READ), addr[c_ABITS-1:0], w_wdata};

   // Address bits above the sent bytes are intentionally ignored.
   assign w_unused_addr = ^addr;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_rx    <= '0;
         r_dout  <= '0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs    <= 1'b1;
         r_mosi  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_rx    <= w_rx_nxt;
         r_dout  <= w_dout_nxt;
         r_we    <= w_we_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_sclk  <= w_sclk_nxt;
         r_cs    <= w_cs_nxt;
         r_mosi  <= w_mosi_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (start)      w_state_nxt = c_SETUP;
         c_SETUP: if (w_div_last) w_state_nxt = c_SHIFT;
         c_SHIFT: if (w_div_last && r_sclk && w_bit_last) w_state_nxt = c_HOLD;
         c_HOLD:  if (w_div_last) w_state_nxt = c_DESEL;
         c_DESEL: if (w_div_last) w_state_nxt = c_IDLE;
         default:                 w_state_nxt = c_IDLE;
      endcase
   end

   // ------------------------------------------------- next outputs / datapath
   always_comb begin
      w_div_nxt   = (r_state == c_IDLE || w_div_last) ? '0 : r_div + c_DIV_ONE;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_rx_nxt    = r_rx;
      w_dout_nxt  = r_dout;
      w_we_nxt    = r_we;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_sclk_nxt  = r_sclk;
      w_cs_nxt    = r_cs;
      w_mosi_nxt  = r_mosi;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_we_nxt    = we;
               w_mosi_nxt  = w_frame[c_NBITS-1];
               w_shift_nxt = {w_frame[c_NBITS-2:0], 1'b0};
               w_bit_nxt   = '0;
               w_cs_nxt    = 1'b0;
               w_sclk_nxt  = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         c_SHIFT: begin
            if (w_div_last) begin
               if (!r_sclk) begin
                  w_sclk_nxt = 1'b1;
               end else begin
                  // Falling edge: capture MISO and start the next bit's low phase.
                  w_sclk_nxt = 1'b0;
                  w_rx_nxt   = {r_rx[30:0], spi_miso};
                  if (w_bit_last) begin
                     w_mosi_nxt = 1'b0;
                  end else begin
                     w_mosi_nxt  = r_shift[c_NBITS-1];
                     w_shift_nxt = {r_shift[c_NBITS-2:0], 1'b0};
                     w_bit_nxt   = r_bit + c_BIT_ONE;
                  end
               end
            end
         end
         c_HOLD: begin
            if (w_div_last) w_cs_nxt = 1'b1;
         end
         c_DESEL: begin
            if (w_div_last) begin
               w_done_nxt = 1'b1;
               w_busy_nxt = 1'b0;
               // First received data byte is the one at addr+0 -> dout[7:0].
               if (!r_we) w_dout_nxt = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
            end
         end
         default: ;
      endcase
   end

   assign dout     = r_dout;
   assign busy     = r_busy;
   assign done     = r_done;
   assign spi_clk  = r_sclk;
   assign spi_cs   = r_cs;
   assign spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spraid_spi_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_spraid_spi_channel
// Purpose  : Self-checking bench for spraid_spi_channel. Instance u_dut0 uses
//            CLK_DIV=2 against a small SPI-SRAM model; u_dut1 uses CLK_DIV=1
//            for back-to-back timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spraid_spi_channel;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        start0, we0, busy0, done0, sclk0, cs0, mosi0;
   logic        miso0 = 1'b0;
   logic [31:0] addr0, din0, dout0;

   logic        start1, we1, busy1, done1, sclk1, cs1, mosi1;
   logic        miso1;
   logic [31:0] addr1, din1, dout1;

   spraid_spi_channel #(.CLK_DIV(2), .ADDR_BYTES(3), .CMD_READ(8'h03), .CMD_WRITE(8'h02)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .we(we0), .addr(addr0), .din(din0),
      .dout(dout0), .busy(busy0), .done(done0), .spi_clk(sclk0), .spi_cs(cs0),
      .spi_mosi(mosi0), .spi_miso(miso0)
   );

   spraid_spi_channel #(.CLK_DIV(1), .ADDR_BYTES(3), .CMD_READ(8'h03), .CMD_WRITE(8'h02)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .we(we1), .addr(addr1), .din(din1),
      .dout(dout1), .busy(busy1), .done(done1), .spi_clk(sclk1), .spi_cs(cs1),
      .spi_mosi(mosi1), .spi_miso(miso1)
   );

   assign miso1 = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------ SPI-SRAM model
   logic [7:0]  mem [0:255];
   logic        m_prev_sclk = 1'b0;
   logic        m_prev_cs   = 1'b1;
   logic        m_pend      = 1'b0;
   int          m_cnt       = 0;
   logic [63:0] m_cap       = '0;
   logic [23:0] m_addr      = '0;

   function automatic logic mbit(input int k, input logic [23:0] a);
      logic [7:0] idx;
      logic [7:0] b;
      if (k < 32 || k > 63) return 1'b0;
      idx = a[7:0] + 8'((k - 32) / 8);
      b   = mem[idx];
      return b[7 - ((k - 32) % 8)];
   endfunction

   // Captures MOSI on SCLK rise; drives the next MISO bit one cycle after each fall.
   always @(negedge clk) begin
      m_prev_sclk <= sclk0;
      m_prev_cs   <= cs0;
      m_pend      <= 1'b0;
      if (m_pend) miso0 <= mbit(m_cnt, m_addr);
      if (m_prev_cs && !cs0) begin
         m_cnt <= 0;
         m_cap <= '0;
         miso0 <= 1'b0;
      end else if (!m_prev_sclk && sclk0) begin
         m_cap <= {m_cap[62:0], mosi0};
         m_cnt <= m_cnt + 1;
         if (m_cnt == 31) m_addr <= {m_cap[22:0], mosi0};
      end
      if (m_prev_sclk && !sclk0) m_pend <= 1'b1;
   end

   // ------------------------------------------------------ transaction runner
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit glitch, output int done_n, output int done_cnt,
                          output int cs_low, output logic busy_pre, output logic busy_done,
                          output logic [31:0] dout_done);
      done_n = -1; done_cnt = 0; cs_low = 0; busy_pre = 1'b0; busy_done = 1'b1;
      dout_done = 'x;
      we0 = w; addr0 = a; din0 = d; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (int n = 0; n <= 290; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         if (!cs0) cs_low++;
         if (done0) begin
            done_cnt++;
            if (done_n < 0) begin
               done_n = n; busy_done = busy0; dout_done = dout0;
            end
         end
         if (n == 261) busy_pre = busy0;
         if (glitch) begin
            if (n == 4 || n == 99) begin
               start0 = 1'b1; addr0 = 32'h00ABCD00; we0 = ~w;
            end else begin
               start0 = 1'b0;
            end
         end
      end
      start0 = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] rmem;
      logic [63:0] exp_frame;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int          dn, dc, csl;
      logic        bp, bd;
      logic [31:0] dd;
      int          d1, d2, r0, r1, rises;
      logic        ps, cs_at_done, cs_after;

      tbl[0] = '{1'b1, 32'h00000123, 32'hDDCCBBAA, 32'h0,          64'h02000123_AABBCCDD, 32'h00000000};
      tbl[1] = '{1'b0, 32'h00000010, 32'h0,        32'h44332211,   64'h03000010_00000000, 32'h44332211};
      tbl[2] = '{1'b1, 32'h00ABCDEF, 32'h12345678, 32'h0,          64'h02ABCDEF_78563412, 32'h44332211};
      tbl[3] = '{1'b0, 32'h00000080, 32'hFFFFFFFF, 32'hA5A55A5A,   64'h03000080_00000000, 32'hA5A55A5A};
      tbl[4] = '{1'b0, 32'hFF123440, 32'h0,        32'h00FF0180,   64'h03123440_00000000, 32'h00FF0180};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      reset = 1'b1;
      start0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
      start1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cs",   64'(cs0),   64'd1);
      chk("reset_sclk", 64'(sclk0), 64'd0);
      chk("reset_mosi", 64'(mosi0), 64'd0);
      chk("reset_busy", 64'(busy0), 64'd0);
      chk("reset_done", 64'(done0), 64'd0);
      chk("reset_dout", 64'(dout0), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Table-driven transactions on CLK_DIV=2.
      for (int i = 0; i < 5; i++) begin
         if (!tbl[i].we)
            for (int k = 0; k < 4; k++)
               mem[8'(tbl[i].addr[7:0] + 8'(k))] = tbl[i].rmem[8*k +: 8];
         run_txn(tbl[i].we, tbl[i].addr, tbl[i].din, 1'b0, dn, dc, csl, bp, bd, dd);
         chk($sformatf("v%0d_frame", i),     m_cap,         tbl[i].exp_frame);
         chk($sformatf("v%0d_sclk_rises", i), 64'(m_cnt),   64'd64);
         chk($sformatf("v%0d_cs_low", i),    64'(csl),      64'd260);
         chk($sformatf("v%0d_done_lat", i),  64'(dn),       64'd262);
         chk($sformatf("v%0d_done_cnt", i),  64'(dc),       64'd1);
         chk($sformatf("v%0d_busy_pre", i),  64'(bp),       64'd1);
         chk($sformatf("v%0d_busy_done", i), 64'(bd),       64'd0);
         chk($sformatf("v%0d_dout", i),      64'(dd),       64'(tbl[i].exp_dout));
      end

      // start pulses while busy must be ignored.
      run_txn(1'b1, 32'h00000555, 32'hCAFEF00D, 1'b1, dn, dc, csl, bp, bd, dd);
      chk("busy_start_frame",    m_cap,       64'h02000555_0DF0FECA);
      chk("busy_start_rises",    64'(m_cnt),  64'd64);
      chk("busy_start_done_cnt", 64'(dc),     64'd1);
      chk("busy_start_done_lat", 64'(dn),     64'd262);

      // Asynchronous reset during bit 20.
      we0 = 1'b0; addr0 = 32'h00000010; din0 = '0; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (84) @(posedge clk);
      #1;
      chk("midrst_pre_cs",   64'(cs0),   64'd0);
      chk("midrst_pre_sclk", 64'(sclk0), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_cs",   64'(cs0),   64'd1);
      chk("midrst_sclk", 64'(sclk0), 64'd0);
      chk("midrst_busy", 64'(busy0), 64'd0);
      chk("midrst_mosi", 64'(mosi0), 64'd0);
      chk("midrst_dout", 64'(dout0), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      run_txn(1'b0, 32'h00000010, 32'h0, 1'b0, dn, dc, csl, bp, bd, dd);
      chk("postrst_frame",    m_cap,      64'h03000010_00000000);
      chk("postrst_rises",    64'(m_cnt), 64'd64);
      chk("postrst_done_lat", 64'(dn),    64'd262);
      chk("postrst_dout",     64'(dd),    64'h44332211);

      // CLK_DIV=1 back-to-back with start held through the done cycle.
      d1 = -1; d2 = -1; r0 = -1; r1 = -1; rises = 0; ps = 1'b0;
      cs_at_done = 1'b0; cs_after = 1'b1;
      we1 = 1'b1; addr1 = 32'h00000042; din1 = 32'h01020304; start1 = 1'b1;
      @(posedge clk); #1;
      chk("b2b_cs_fall", 64'(cs1), 64'd0);
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (sclk1 && !ps && d1 < 0) begin
            rises++;
            if (r0 < 0) r0 = n;
            else if (r1 < 0) r1 = n;
         end
         ps = sclk1;
         if (done1) begin
            if (d1 < 0) d1 = n;
            else if (d2 < 0) d2 = n;
         end
         if (d1 >= 0 && n == d1) cs_at_done = cs1;
         if (d1 >= 0 && n == d1 + 1) begin
            cs_after = cs1;
            start1 = 1'b0;
         end
      end
      start1 = 1'b0;
      chk("b2b_done_lat",     64'(d1),         64'd131);
      chk("b2b_first_rise",   64'(r0),         64'd2);
      chk("b2b_sclk_period",  64'(r1 - r0),    64'd2);
      chk("b2b_rises",        64'(rises),      64'd64);
      chk("b2b_cs_in_done",   64'(cs_at_done), 64'd1);
      chk("b2b_cs_after",     64'(cs_after),   64'd0);
      chk("b2b_second_done",  64'(d2),         64'd263);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
